// File: rtl/cnn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_ctrl_pkg
//  Description : Shared types and constants for the CNN frame controller.
//                Provides the controller state encoding, the padding-mode
//                codes and the default address/counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_ctrl_pkg;

    // Default widths used by the controller, the bus interface and the geometry helper.
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 16;

    // Padding-mode codes carried on cfg_pad_mode / padding_mode. 2'b11 is illegal.
    localparam logic [1:0] PAD_NONE = 2'b00;
    localparam logic [1:0] PAD_ZERO = 2'b01;
    localparam logic [1:0] PAD_EDGE = 2'b10;

    // Frame controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage : cnn_ctrl_pkg
`default_nettype wire

// File: rtl/cnn_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_frame_ctrl_if
//  Description : Data-path bus of the CNN frame controller: image-memory read
//                port, pixel stream into the pipeline, result stream out of
//                the pipeline and result-memory write port.
//                master = controller side, slave = memories/pipeline side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cnn_frame_ctrl_if
    import cnn_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    // Image memory read port (1-cycle read latency).
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              mem_rd_data;

    // Pixel stream into the conv/ReLU/pool pipeline.
    logic                    pix_valid;
    logic signed [7:0]       pix_data;

    // Pooled results coming back from the pipeline.
    logic                    res_valid;
    logic signed [7:0]       res_data;

    // Result memory write port.
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [7:0]              wr_data;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output pix_valid,
        output pix_data,
        input  res_valid,
        input  res_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  pix_valid,
        input  pix_data,
        output res_valid,
        output res_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface : cnn_frame_ctrl_if
`default_nettype wire

// File: rtl/cnn_frame_geom.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_frame_geom
//  Description : Purely combinational frame geometry. From W, H and the pad
//                mode it derives the pixel count N = W*H, the number of
//                pooled results E = (FW-2)*(FH-2), and whether the
//                configuration can be processed at all. Without padding the
//                3x3 conv trims two rows/columns, hence FW = W-2.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_frame_geom
    import cnn_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic [7:0]       width,
    input  logic [7:0]       height,
    input  logic [1:0]       pad_mode,
    output logic [CNT_W-1:0] pix_total,
    output logic [CNT_W-1:0] res_total,
    output logic             cfg_ok
);

    logic [7:0] w_fw;
    logic [7:0] w_fh;

    // Effective conv output size; widths below 2 clamp to 0 so they fail the >=3 test.
    always_comb begin
        w_fw = width;
        w_fh = height;
        if (pad_mode == PAD_NONE) begin
            w_fw = (width  >= 8'd2) ? (width  - 8'd2) : 8'd0;
            w_fh = (height >= 8'd2) ? (height - 8'd2) : 8'd0;
        end
    end

    // Legality check, pixel count and expected pooled-result count.
    always_comb begin
        cfg_ok    = (pad_mode != 2'b11) && (w_fw >= 8'd3) && (w_fh >= 8'd3);
        pix_total = CNT_W'(width) * CNT_W'(height);
        res_total = '0;
        if (cfg_ok) begin
            res_total = CNT_W'(w_fw - 8'd2) * CNT_W'(w_fh - 8'd2);
        end
    end

endmodule : cnn_frame_geom
`default_nettype wire

// File: rtl/cnn_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_frame_ctrl
//  Description : Frame-level sequencer for the conv->ReLU->pool pipeline.
//                Latches a frame command, validates it, streams W*H pixels
//                from image memory at one pixel per cycle, writes each pooled
//                result to result memory and pulses done once the expected
//                result count has arrived.
//                Optional feature macro: CNN_CTRL_TIMEOUT_EN enables a DRAIN
//                watchdog that raises err after TIMEOUT_CYC idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_frame_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_width,
    input  logic [7:0]        cfg_height,
    input  logic [1:0]        cfg_pad_mode,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              dp_rst_n,
    output logic [7:0]        img_width,
    output logic [7:0]        img_height,
    output logic [1:0]        padding_mode,
    output logic [CNT_W-1:0]  out_count,
    cnn_frame_ctrl_if.master  bus
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_width;
    logic [7:0]        r_height;
    logic [1:0]        r_pad;
    logic [ADDR_W-1:0] r_img_base;
    logic [ADDR_W-1:0] r_out_base;

    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_err;
    logic              r_dp_rst_n;
    logic              r_pix_valid;

    logic [CNT_W-1:0]  w_pix_total;
    logic [CNT_W-1:0]  w_res_total;
    logic              w_cfg_ok;

    logic              w_start_ok;
    logic              w_mem_rd_en;
    logic              w_accept;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_last_read;
    logic              w_to_hit;

    // Geometry is derived from the latched config, which is stable while busy.
    cnn_frame_geom #(
        .CNT_W     (CNT_W)
    ) u_geom (
        .width     (r_width),
        .height    (r_height),
        .pad_mode  (r_pad),
        .pix_total (w_pix_total),
        .res_total (w_res_total),
        .cfg_ok    (w_cfg_ok)
    );

    // A start only counts in IDLE and never together with abort.
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;

    // Results are only taken while a frame is in flight and still short of E.
    assign w_accept     = bus.res_valid && !abort &&
                          ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) &&
                          (r_out_count < w_res_total);
    assign w_count_next = r_out_count + {{(CNT_W-1){1'b0}}, w_accept};
    assign w_last_read  = (r_idx == (w_pix_total - 1'b1));

`ifdef CNN_CTRL_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_to_w-1:0] r_to_cnt;

    // DRAIN watchdog: restarts on every accepted result, idles at zero elsewhere.
    always_ff @(posedge clk) begin
        if (!rst_n || (r_state != ST_DRAIN) || w_accept) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_to_hit = (r_to_cnt == c_to_w'(TIMEOUT_CYC - 1)) && !w_accept;
`else
    logic [31:0] w_timeout_unused;

    assign w_timeout_unused = 32'(TIMEOUT_CYC);
    assign w_to_hit         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the image read strobe; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_rd_en = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_nxt = w_cfg_ok ? ST_STREAM : ST_ERR;
            end
            ST_STREAM: begin
                w_mem_rd_en = 1'b1;
                if (w_last_read) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_count_next == w_res_total) begin
                    w_state_nxt = ST_DONE;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_mem_rd_en = 1'b0;
        end
    end

    // Frame configuration captured on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_width    <= '0;
            r_height   <= '0;
            r_pad      <= '0;
            r_img_base <= '0;
            r_out_base <= '0;
        end else if (w_start_ok) begin
            r_width    <= cfg_width;
            r_height   <= cfg_height;
            r_pad      <= cfg_pad_mode;
            r_img_base <= img_base;
            r_out_base <= out_base;
        end
    end

    // Pixel read index: cleared in CHECK, advanced on every issued read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (r_state == ST_CHECK) begin
            r_idx <= '0;
        end else if (w_mem_rd_en) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Result counter and sticky error flag, both cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_count <= '0;
            r_err       <= 1'b0;
        end else if (w_start_ok) begin
            r_out_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_count <= w_count_next;
            if (w_state_nxt == ST_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    // Datapath reset pulse (CHECK cycle and the cycle after an abort) and pixel valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dp_rst_n  <= 1'b1;
            r_pix_valid <= 1'b0;
        end else begin
            r_dp_rst_n  <= !((w_state_nxt == ST_CHECK) || abort);
            r_pix_valid <= w_mem_rd_en;
        end
    end

    assign busy         = (r_state == ST_CHECK) || (r_state == ST_STREAM) ||
                          (r_state == ST_DRAIN);
    assign done         = (r_state == ST_DONE);
    assign err          = r_err;
    assign dp_rst_n     = r_dp_rst_n;
    assign img_width    = r_width;
    assign img_height   = r_height;
    assign padding_mode = r_pad;
    assign out_count    = r_out_count;

    assign bus.mem_rd_en = w_mem_rd_en;
    assign bus.mem_addr  = w_mem_rd_en ? (r_img_base + ADDR_W'(r_idx)) : '0;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_data  = $signed(bus.mem_rd_data);
    assign bus.wr_en     = w_accept;
    assign bus.wr_addr   = w_accept ? (r_out_base + ADDR_W'(r_out_count)) : '0;
    assign bus.wr_data   = w_accept ? $unsigned(bus.res_data) : 8'd0;

endmodule : cnn_frame_ctrl
`default_nettype wire

// File: tb/tb_cnn_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_frame_ctrl
//  Description : Self-checking bench for cnn_frame_ctrl with an image-memory
//                model, a pipeline model and scoreboards for reads, pixels
//                and result writes. Timeout scenario runs when
//                CNN_CTRL_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_frame_ctrl;
    import cnn_ctrl_pkg::*;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int TO_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        cfg_width = '0;
    logic [7:0]        cfg_height = '0;
    logic [1:0]        cfg_pad_mode = '0;
    logic [ADDR_W-1:0] img_base = '0;
    logic [ADDR_W-1:0] out_base = '0;
    logic              busy, done, err, dp_rst_n;
    logic [7:0]        img_width, img_height;
    logic [1:0]        padding_mode;
    logic [CNT_W-1:0]  out_count;

    cnn_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    cnn_frame_ctrl #(
        .ADDR_W       (ADDR_W),
        .CNT_W        (CNT_W),
        .TIMEOUT_CYC  (TO_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_pad_mode (cfg_pad_mode),
        .img_base     (img_base),
        .out_base     (out_base),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .dp_rst_n     (dp_rst_n),
        .img_width    (img_width),
        .img_height   (img_height),
        .padding_mode (padding_mode),
        .out_count    (out_count),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboards
    logic [15:0] rd_q [$];
    logic [7:0]  px_q [$];
    logic [23:0] wr_q [$];

    // Pipeline model configuration
    int          m_n, m_e, m_extra, m_pk, m_wk;
    bit          m_en = 1'b0;
    logic [15:0] m_ob;
    logic [7:0]  m_d;

    // Frame statistics
    int f_reads, f_first_k, f_last_k, f_done_cnt, f_done_k, f_dp_low;
    int f_busy_low_k, f_err_k, f_err_k1, f_writes, f_e, f_n;

    // Image memory model: data = low address byte XOR 0x5A, one cycle after the read.
    always @(posedge clk) begin
        bus.mem_rd_data <= bus.mem_rd_en ? (bus.mem_addr[7:0] ^ 8'h5A) : 8'h00;
    end

    // Pipeline model: emits a result one cycle after each of the last E+extra pixels.
    always @(posedge clk) begin
        bus.res_valid <= 1'b0;
        bus.res_data  <= '0;
        if (bus.pix_valid === 1'b1) begin
            if (m_en && (m_pk >= m_n - m_e - m_extra)) begin
                m_d = bus.pix_data ^ 8'hC3;
                bus.res_valid <= 1'b1;
                bus.res_data  <= $signed(m_d);
                if (m_wk < m_e) wr_q.push_back({16'(m_ob + 16'(m_wk)), m_d});
                m_wk++;
            end
            m_pk++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Runs one frame command and checks reads, pixels and writes as they occur.
    task automatic do_frame(input int w, input int h, input int pad, input int ib, input int ob,
                            input int extra, input int abort_k, input bit mid_start, input bit no_res);
        int   fw, fh, k;
        bit   ok, ended;
        logic [15:0] a;
        logic [15:0] ea;
        logic [7:0]  ep;
        logic [23:0] ew;
        fw = (pad == 0) ? w - 2 : w;
        fh = (pad == 0) ? h - 2 : h;
        ok = (pad != 3) && (fw >= 3) && (fh >= 3);
        f_e = ok ? (fw - 2) * (fh - 2) : 0;
        f_n = w * h;
        rd_q.delete(); px_q.delete(); wr_q.delete();
        if (ok) begin
            for (int i = 0; i < f_n; i++) begin
                a = 16'(ib + i);
                rd_q.push_back(a);
                px_q.push_back(a[7:0] ^ 8'h5A);
            end
        end
        f_reads = 0; f_first_k = -1; f_last_k = -1; f_done_cnt = 0; f_done_k = -1;
        f_dp_low = 0; f_busy_low_k = -1; f_err_k = -1; f_err_k1 = -1; f_writes = 0;
        @(posedge clk); #1;
        m_n = f_n; m_e = f_e; m_extra = extra; m_pk = 0; m_wk = 0; m_ob = 16'(ob); m_en = !no_res;
        cfg_width = 8'(w); cfg_height = 8'(h); cfg_pad_mode = 2'(pad);
        img_base = 16'(ib); out_base = 16'(ob); start = 1'b1;
        k = 0; ended = 1'b0;
        while (!ended) begin
            @(posedge clk); #1;
            k++;
            start = mid_start && (k == 5);
            if (mid_start && k == 5) cfg_width = 8'd9;
            abort = (abort_k != 0) && (k == abort_k);
            if (abort_k != 0 && k == abort_k) begin
                rd_q.delete();
                m_en = 1'b0;
            end
            if (abort_k != 0 && k == abort_k + 1) begin
                px_q.delete();
                wr_q.delete();
            end
            #3;
            if (k == 1) f_err_k1 = int'(err);
            if (!dp_rst_n) f_dp_low++;
            if (mid_start && k == 8) begin
                n_cmp++;
                if (img_width !== 8'(w)) begin
                    n_bad++; $display("FAIL ignored_start_width: got %0d expected %0d", img_width, w);
                end
            end
            if (abort_k != 0 && k == abort_k) begin
                n_cmp++;
                if (bus.mem_rd_en !== 1'b0) begin
                    n_bad++; $display("FAIL abort_rd_en: got %b expected 0", bus.mem_rd_en);
                end
            end
            if (abort_k != 0 && k == abort_k + 1) begin
                n_cmp++;
                if (dp_rst_n !== 1'b0) begin
                    n_bad++; $display("FAIL abort_dp_rst_n: got %b expected 0", dp_rst_n);
                end
            end
            if (bus.mem_rd_en === 1'b1) begin
                f_reads++;
                if (f_first_k < 0) f_first_k = k;
                f_last_k = k;
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_bad++; $display("FAIL read_addr: got unexpected read at %0h expected none", bus.mem_addr);
                end else begin
                    ea = rd_q.pop_front();
                    if (bus.mem_addr !== ea) begin
                        n_bad++; $display("FAIL read_addr: got %0h expected %0h", bus.mem_addr, ea);
                    end
                end
            end
            if (bus.pix_valid === 1'b1) begin
                n_cmp++;
                if (px_q.size() == 0) begin
                    n_bad++; $display("FAIL pix_data: got unexpected pixel %0h expected none", bus.pix_data);
                end else begin
                    ep = px_q.pop_front();
                    if ($unsigned(bus.pix_data) !== ep) begin
                        n_bad++; $display("FAIL pix_data: got %0h expected %0h", bus.pix_data, ep);
                    end
                end
            end
            if (bus.wr_en === 1'b1) begin
                f_writes++;
                n_cmp++;
                if (wr_q.size() == 0) begin
                    n_bad++; $display("FAIL write: got unexpected write %0h/%0h expected none", bus.wr_addr, bus.wr_data);
                end else begin
                    ew = wr_q.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== ew) begin
                        n_bad++; $display("FAIL write: got %0h/%0h expected %0h/%0h",
                                          bus.wr_addr, bus.wr_data, ew[23:8], ew[7:0]);
                    end
                end
            end
            if (done === 1'b1) begin
                f_done_cnt++;
                f_done_k = k;
            end
            if (busy !== 1'b1 && f_busy_low_k < 0 && k >= 2) f_busy_low_k = k;
            if (err === 1'b1 && f_err_k < 0) f_err_k = k;
            if (done === 1'b1) ended = 1'b1;
            else if (f_busy_low_k >= 0 && k >= f_busy_low_k + 1) ended = 1'b1;
            else if (k > f_n + 300) begin
                n_cmp++; n_bad++;
                $display("FAIL frame_timeout: got no completion after %0d cycles expected completion", k);
                ended = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (rd_q.size() != 0 || px_q.size() != 0 || wr_q.size() != 0) begin
            n_bad++; $display("FAIL leftover: got %0d/%0d/%0d pending reads/pixels/writes expected 0/0/0",
                              rd_q.size(), px_q.size(), wr_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b expected 0", bus.mem_rd_en); end
        n_cmp++; if (bus.mem_addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr: got %0h expected 0", bus.mem_addr); end
        n_cmp++; if (bus.pix_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pix_valid: got %b expected 0", bus.pix_valid); end
        n_cmp++; if (dp_rst_n !== 1'b1) begin n_bad++; $display("FAIL reset_dp_rst_n: got %b expected 1", dp_rst_n); end
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
        n_cmp++; if (out_count !== 16'd0) begin n_bad++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
        n_cmp++; if ({img_width, img_height, padding_mode} !== 18'd0) begin
            n_bad++; $display("FAIL reset_cfg: got %0d/%0d/%0d expected 0/0/0", img_width, img_height, padding_mode);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_frame(5, 5, 0, 'h100, 'h200, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (f_reads != 25) begin n_bad++; $display("FAIL basic_reads: got %0d expected 25", f_reads); end
        n_cmp++; if (f_first_k != 2 || f_last_k != 26) begin
            n_bad++; $display("FAIL basic_read_window: got %0d..%0d expected 2..26", f_first_k, f_last_k);
        end
        n_cmp++; if (f_dp_low != 1) begin n_bad++; $display("FAIL basic_dp_rst: got %0d low cycles expected 1", f_dp_low); end
        n_cmp++; if (f_done_cnt != 1 || f_done_k != 29) begin
            n_bad++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 29", f_done_cnt, f_done_k);
        end
        n_cmp++; if (f_writes != 1 || out_count !== 16'd1) begin
            n_bad++; $display("FAIL basic_count: got %0d writes count %0d expected 1/1", f_writes, out_count);
        end
    endtask

    task automatic test_pad_zero();
        do_frame(8, 6, 1, 'h0400, 'h0800, 3, 0, 1'b0, 1'b0);
        n_cmp++; if (f_reads != 48) begin n_bad++; $display("FAIL pad_reads: got %0d expected 48", f_reads); end
        n_cmp++; if (f_writes != 24 || out_count !== 16'd24) begin
            n_bad++; $display("FAIL pad_count: got %0d writes count %0d expected 24/24", f_writes, out_count);
        end
        n_cmp++; if (f_done_cnt != 1 || f_done_k != 51) begin
            n_bad++; $display("FAIL pad_done: got %0d pulses at %0d expected 1 at 51", f_done_cnt, f_done_k);
        end
        n_cmp++; if (padding_mode !== PAD_ZERO || img_height !== 8'd6) begin
            n_bad++; $display("FAIL pad_cfg_out: got %0d/%0d expected 1/6", padding_mode, img_height);
        end
    endtask

    task automatic test_cfg_err();
        do_frame(4, 8, 0, 'h0000, 'h0100, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (f_reads != 0) begin n_bad++; $display("FAIL err_reads: got %0d expected 0", f_reads); end
        n_cmp++; if (f_err_k != 2 || f_busy_low_k != 2) begin
            n_bad++; $display("FAIL err_timing: got err at %0d busy low at %0d expected 2/2", f_err_k, f_busy_low_k);
        end
        n_cmp++; if (f_done_cnt != 0) begin n_bad++; $display("FAIL err_done: got %0d expected 0", f_done_cnt); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected 1", err); end
        do_frame(5, 5, 3, 'h0000, 'h0100, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (f_err_k != 2 || f_reads != 0) begin
            n_bad++; $display("FAIL err_pad11: got err at %0d reads %0d expected 2/0", f_err_k, f_reads);
        end
        do_frame(5, 5, 2, 'hFFF0, 'h0300, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (f_err_k1 != 0) begin n_bad++; $display("FAIL err_clear: got %0d expected 0", f_err_k1); end
        n_cmp++; if (f_done_cnt != 1 || out_count !== 16'd9) begin
            n_bad++; $display("FAIL edge_frame: got %0d pulses count %0d expected 1/9", f_done_cnt, out_count);
        end
    endtask

    task automatic test_abort();
        do_frame(8, 8, 1, 'h0200, 'h0600, 0, 11, 1'b0, 1'b0);
        n_cmp++; if (f_reads != 9) begin n_bad++; $display("FAIL abort_reads: got %0d expected 9", f_reads); end
        n_cmp++; if (f_done_cnt != 0) begin n_bad++; $display("FAIL abort_done: got %0d expected 0", f_done_cnt); end
        n_cmp++; if (f_dp_low != 2 || f_busy_low_k != 12) begin
            n_bad++; $display("FAIL abort_status: got dp low %0d busy low at %0d expected 2/12", f_dp_low, f_busy_low_k);
        end
        do_frame(5, 5, 0, 'h0020, 'h0700, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (f_done_cnt != 1 || out_count !== 16'd1) begin
            n_bad++; $display("FAIL abort_recover: got %0d pulses count %0d expected 1/1", f_done_cnt, out_count);
        end
    endtask

    task automatic test_start_ignored();
        do_frame(5, 5, 0, 'h0050, 'h0900, 0, 0, 1'b1, 1'b0);
        n_cmp++; if (f_reads != 25 || f_done_cnt != 1 || out_count !== 16'd1) begin
            n_bad++; $display("FAIL ignored_start_frame: got %0d reads %0d pulses count %0d expected 25/1/1",
                              f_reads, f_done_cnt, out_count);
        end
    endtask

    task automatic test_back_to_back();
        do_frame(6, 5, 0, 'h1000, 'h2000, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (f_done_cnt != 1 || out_count !== 16'd2) begin
            n_bad++; $display("FAIL b2b_first: got %0d pulses count %0d expected 1/2", f_done_cnt, out_count);
        end
        do_frame(5, 6, 0, 'h3000, 'h4000, 0, 0, 1'b0, 1'b0);
        n_cmp++; if (f_first_k != 2 || f_done_k != 34 || out_count !== 16'd2) begin
            n_bad++; $display("FAIL b2b_second: got first read %0d done %0d count %0d expected 2/34/2",
                              f_first_k, f_done_k, out_count);
        end
    endtask

`ifdef CNN_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        do_frame(5, 5, 0, 'h0100, 'h0200, 0, 0, 1'b0, 1'b1);
        n_cmp++; if (f_err_k != 27 + TO_CYC || f_done_cnt != 0) begin
            n_bad++; $display("FAIL timeout: got err at %0d pulses %0d expected %0d/0", f_err_k, f_done_cnt, 27 + TO_CYC);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_pad_zero();
        test_cfg_err();
        test_abort();
        test_start_ignored();
        test_back_to_back();
`ifdef CNN_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cnn_frame_ctrl
`default_nettype wire
